// File: rtl/pathseg_pkg.sv
// Shared types and helpers for the path-segmented datapath result collector.
// sat_add is only referenced when PATHSEG_ACC_SAT_EN is defined.
package pathseg_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } state_t;

  // Unsigned add of two operands, clamped to 2^w-1 (w < 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (s > lim) sat_add = lim[63:0];
    else         sat_add = s[63:0];
  endfunction

endpackage

// File: rtl/pathseg_sum_fifo.sv
// First-word-fall-through FIFO for completed block sums.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module pathseg_sum_fifo
  import pathseg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = LW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + LW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + LW'(1);
    end
  end

endmodule

// File: rtl/pathseg_result_collector.sv
// Re-aligns issue tags to datapath results and queues one sum per N results.
// Define PATHSEG_ACC_SAT_EN to clamp every add at 2^ACC_W-1 instead of wrapping.
//
//   state | meaning
//   ACCUM | adding aligned results, fewer than N-1 taken so far
//   LAST  | next aligned result completes the block sum
module pathseg_result_collector
  import pathseg_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int N     = 4,
  parameter int ACC_W = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue,
  input  logic                         clr,
  input  logic [DATA_W-1:0]            din,
  output logic [ACC_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         ovf,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int CW = $clog2(N);

  logic [LAT-1:0]   tag;
  logic             take;
  state_t           state;
  state_t           state_nxt;
  logic             acc_en;
  logic             push;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;

  generate
    if (LAT == 1) begin : g_tag1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      tag <= '0;
        else if (clr) tag <= '0;
        else          tag <= issue;
      end
    end else begin : g_tagn
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      tag <= '0;
        else if (clr) tag <= '0;
        else          tag <= {tag[LAT-2:0], issue};
      end
    end
  endgenerate

  assign take = tag[LAT-1];

`ifdef PATHSEG_ACC_SAT_EN
  assign sum = ACC_W'(sat_add(64'(acc), 64'(din), ACC_W));
`else
  assign sum = acc + ACC_W'(din);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= ACCUM;
    else if (clr) state <= ACCUM;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (take && (cnt == CW'(N-2))) state_nxt = LAST;
      LAST:    if (take) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    acc_en = 1'b0;
    push   = 1'b0;
    case (state)
      ACCUM:   acc_en = take;
      LAST:    push   = take;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_en) begin
      acc <= sum;
      cnt <= cnt + CW'(1);
    end else if (push) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  // A full FIFO still accepts the sum if the head leaves in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ovf <= 1'b0;
    else if (clr)                          ovf <= 1'b0;
    else if (push && full && !out_ready)   ovf <= 1'b1;
  end

  pathseg_sum_fifo #(
    .DEPTH (DEPTH),
    .W     (ACC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (out_ready),
    .wdata (sum),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_pathseg_result_collector.sv
// Directed bench for pathseg_result_collector (LAT=2, N=4, DEPTH=4), plus an
// ACC_W=16 instance sharing the same stimulus for the overflow-mode check.
module tb_pathseg_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue;
  logic        clr;
  logic        out_ready;
  logic [15:0] din;

  logic [17:0] out_data;
  logic        out_valid;
  logic        ovf;
  logic [2:0]  level;

  logic [15:0] out_data16;
  logic        out_valid16;
  logic        ovf16;
  logic [2:0]  level16;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [1:0]  tb_tag;
  logic [15:0] vals[$];

  int          n;
  logic        got;
  logic [9:0]  pat;

  always #5 clk = ~clk;

  pathseg_result_collector u_dut (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .clr       (clr),
    .din       (din),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .level     (level)
  );

  pathseg_result_collector #(.ACC_W(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .clr       (clr),
    .din       (din),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .ovf       (ovf16),
    .level     (level16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: din carries the next queued value only on aligned cycles.
  task automatic tick(input logic iss, input logic rdy, input logic clr_v);
    issue     = iss;
    out_ready = rdy;
    clr       = clr_v;
    if (!clr_v && tb_tag[1] && vals.size() > 0) din = vals.pop_front();
    else din = 16'($urandom_range(0, 65535));
    if (clr_v) begin
      tb_tag = '0;
      vals.delete();
    end else begin
      tb_tag = {tb_tag[0], iss};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    vals.push_back(a);
    vals.push_back(b);
    vals.push_back(c);
    vals.push_back(d);
  endtask

  task automatic wait_valid(output int cyc, output logic seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 1'b0);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; issue = 1'b0; clr = 1'b0; out_ready = 1'b0; din = '0; tb_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_ovf",   ovf,       0);
    chk("rst_level", level,     0);

    // basic sum 1+2+3+4
    load4(1, 2, 3, 4);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_valid(n, got);
    chk("basic_valid", got, 1);
    chk("basic_lat",   n,   2);
    chk("basic_sum",   out_data, 10);
    chk("basic_level", level, 1);
    tick(1'b0, 1'b1, 1'b0);
    chk("basic_one_cycle", out_valid, 0);
    chk("basic_level0",    level, 0);

    // gapped issue, garbage on non-aligned cycles
    load4(7, 100, 1000, 3);
    pat = 10'b1000100101;
    for (int i = 0; i < 10; i++) tick(pat[i], 1'b0, 1'b0);
    wait_valid(n, got);
    chk("gap_valid", got, 1);
    chk("gap_sum",   out_data, 1110);
    tick(1'b0, 1'b1, 1'b0);
    chk("gap_level0", level, 0);

    // overrun: five blocks of four 1s, no consumer
    for (int i = 0; i < 20; i++) vals.push_back(16'd1);
    for (int i = 0; i < 24; i++) begin
      tick(i < 20, 1'b0, 1'b0);
      if (i == 20) begin
        chk("ovr_level4",  level, 4);
        chk("ovr_ovf_pre", ovf,   0);
      end
      if (i == 21) begin
        chk("ovr_ovf",      ovf,   1);
        chk("ovr_level_kp", level, 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk("ovr_head_valid", out_valid, 1);
      chk("ovr_head",       out_data,  4);
      tick(1'b0, 1'b1, 1'b0);
    end
    chk("ovr_drained",  level,     0);
    chk("ovr_empty",    out_valid, 0);
    chk("ovr_sticky",   ovf,       1);
    tick(1'b0, 1'b1, 1'b0);
    chk("ovr_pop_empty", level, 0);
    tick(1'b0, 1'b0, 1'b1);
    chk("ovr_clr", ovf, 0);

    // full FIFO with push and pop together
    load4(1, 2, 3, 4);
    load4(5, 5, 5, 5);
    load4(6, 7, 8, 9);
    load4(10, 10, 10, 10);
    load4(11, 12, 13, 14);
    for (int i = 0; i < 24; i++) begin
      tick(i < 20, i == 21, 1'b0);
      if (i == 20) chk("pp_full", level, 4);
      if (i == 21) begin
        chk("pp_level", level,    4);
        chk("pp_ovf",   ovf,      0);
        chk("pp_head",  out_data, 20);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", out_data, 32'(20 + 10 * i));
      tick(1'b0, 1'b1, 1'b0);
    end
    chk("pp_level0", level, 0);

    // reset mid-block
    vals.push_back(9);
    vals.push_back(9);
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tb_tag = '0;
    vals.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_level", level, 0);
    load4(5, 5, 5, 5);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_valid(n, got);
    chk("rstmid_valid", got, 1);
    chk("rstmid_sum",   out_data, 20);
    tick(1'b0, 1'b1, 1'b0);

    // clr mid-block
    vals.push_back(9);
    vals.push_back(9);
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    load4(5, 5, 5, 5);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_valid(n, got);
    chk("clrmid_valid", got, 1);
    chk("clrmid_sum",   out_data, 20);
    tick(1'b0, 1'b1, 1'b0);

    // clr with tags still in flight
    vals.push_back(9);
    vals.push_back(9);
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    load4(5, 5, 5, 5);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_valid(n, got);
    chk("clrfly_valid", got, 1);
    chk("clrfly_sum",   out_data, 20);
    tick(1'b0, 1'b1, 1'b0);
    chk("clrfly_level0", level, 0);

    // wide vs 16-bit accumulator with 4 x FFFF
    tick(1'b0, 1'b0, 1'b1);
    load4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    wait_valid(n, got);
    chk("sat_valid",    got, 1);
    chk("sat_wide",     out_data, 32'h3FFFC);
    chk("sat_valid16",  out_valid16, 1);
`ifdef PATHSEG_ACC_SAT_EN
    chk("sat_narrow",   out_data16, 32'hFFFF);
`else
    chk("sat_narrow",   out_data16, 32'hFFFC);
`endif
    tick(1'b0, 1'b1, 1'b0);
    chk("sat_level0",   level16, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pathseg_result_collector.md
# pathseg_result_collector

Downstream stage of the path-segmented add/multiply datapath. It tags each operand issue, re-aligns that tag to the datapath's registered 16-bit result after the fixed pipeline latency, and accumulates every N aligned results into one block sum. Each sum is queued in a small FIFO with a valid/ready output handshake. FIFO overrun is flagged and never stalls the datapath, which has no backpressure input.

## Interface
- `LAT`, 2: cycles from operand issue to a valid `din`; must be ≥ 1.
- `N`, 4: results per block sum; must be ≥ 2.
- `ACC_W`, 18: accumulator and output width; must be ≥ 16.
- `DEPTH`, 4: sum FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue`  in  1  operands presented to the datapath this cycle.
- `clr`  in  1  synchronous clear of tag pipe, count, accumulator, FIFO and `ovf`.
- `din`  in  16  datapath result output.
- `out_data`  out  ACC_W  FIFO head block sum.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `ovf`  out  1  sticky: a completed sum was dropped.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Tag pipe: a LAT-deep shift register of `issue`. Its tail is `take`. When `take`=1, `din` is sampled that cycle.
- Two-state FSM:
  - ACCUM (reset state): on `take`, `acc <= acc + din` and `cnt <= cnt+1`. When `cnt` = N-2, move to LAST.
  - LAST: on `take`, enqueue `acc + din`, clear `acc` and `cnt` to 0, return to ACCUM. Without `take`, hold.
- Enqueue when full and no pop: the sum is discarded, `ovf` <= 1, and FIFO contents are unchanged.
- Enqueue and pop in the same cycle when full: both succeed, `level` unchanged, `ovf` unchanged.
- Pop: `out_valid && out_ready`. `out_ready` while empty has no effect.
- `clr` takes priority over `take`, enqueue and pop in the same cycle. All state returns to its reset value, so tags already in flight are lost.
- `rst` mid-block: partial sum and in-flight tags are discarded. There is no recovery.
- Reset values: `out_valid`=0, `out_data`=0, `ovf`=0, `level`=0, FSM=ACCUM, `acc`=0, `cnt`=0, tag pipe all 0.
- Arithmetic: unsigned. `din` is zero-extended to ACC_W. Overflow behaviour is set by Configuration.

## Timing
- `issue` at cycle t gives `take` at t+LAT.
- The block's final `take` at cycle u gives `out_valid`=1 at u+1 when the FIFO was empty. `out_data` is registered.
- Back-to-back `issue` every cycle is sustained. This gives one sum every N cycles at full rate.
- `out_data` and `out_valid` hold while `out_ready`=0.
- The FIFO is first-word-fall-through: a new head appears the cycle after the pop.
- `ovf` asserts the cycle after the dropped enqueue.

## Configuration
- `PATHSEG_ACC_SAT_EN` defined: every add (`acc+din`, including the final sum) clamps to 2^ACC_W-1.
- Not defined: additions wrap modulo 2^ACC_W.
- With default parameters (ACC_W ≥ 16+$clog2(N)), the two modes are observably identical.

## Structure
- Shared package `pathseg_pkg`:
  - FSM state enum {ACCUM, LAST}.
  - Data width constant DATA_W=16.
  - `sat_add` function, used only under the macro.
- One sub-module, `pathseg_sum_fifo`: parameters DEPTH and width. It provides push/pop, first-word-fall-through head, level, full and empty.
- Tag pipe, FSM, accumulator and `ovf` live in the top module.

## Test plan
- Basic sum: LAT=2, N=4; `issue` on 4 consecutive cycles with `din` = 1,2,3,4 at the aligned cycles; `out_ready`=1 -> `out_data`=10, `out_valid` high exactly one cycle, `level` returns to 0.
- Gapped issue: issues separated by 0-3 idle cycles, `din` = garbage on non-aligned cycles -> sum counts aligned samples only.
- Overrun: `out_ready`=0, 5 blocks of four 1s -> `level`=4, `ovf`=1 after the 5th. Then drain: 4 pops of 4, `ovf` stays 1 until `clr`.
- Full push+pop: FIFO full; `out_ready`=1 in the same cycle the 5th sum completes -> `level` stays 4, `ovf`=0, order preserved.
- Reset mid-block: assert `rst` after 2 of 4 samples, then a fresh block of 5,5,5,5 -> `out_data`=20. A `clr` pulse in place of `rst` gives the same result.
- Saturation: ACC_W=16, N=4, `din`=16'hFFFF ×4 -> 16'hFFFF with `PATHSEG_ACC_SAT_EN`, 16'hFFFC without it.
